// File: rtl/mem_byte_seq.sv
// Byte-serial load/store sequencer in front of a 1024x8 RAM: moves 1, 2 or 4
// little-endian bytes one per cycle and sign/zero-extends load results.
module mem_byte_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [9:0]  addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic [9:0]  ram_addr,
   output logic [7:0]  ram_d,
   output logic        ram_we,
   input  logic [7:0]  ram_q
);

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t      state;
   logic [1:0]  k;
   logic [1:0]  last_k;
   logic        l_wr;
   logic        l_uns;
   logic [1:0]  l_size;
   logic [31:0] l_wdata;
   logic [31:0] rbuf;
   logic [31:0] assembled;
   logic [31:0] load_val;
   logic [1:0]  k_nxt;

   // The final byte of a load comes straight from ram_q on the last XFER edge,
   // so the extended result is formed from the buffer plus the live read byte.
   always_comb begin
      last_k    = (l_size == 2'b00) ? 2'd0 : (l_size == 2'b01) ? 2'd1 : 2'd3;
      k_nxt     = k + 2'd1;
      assembled = rbuf;
      assembled[{k, 3'b000} +: 8] = ram_q;
      case (l_size)
         2'b00:   load_val = {{24{~l_uns & assembled[7]}},  assembled[7:0]};
         2'b01:   load_val = {{16{~l_uns & assembled[15]}}, assembled[15:0]};
         default: load_val = assembled;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         k        <= 2'd0;
         l_wr     <= 1'b0;
         l_uns    <= 1'b0;
         l_size   <= 2'b00;
         l_wdata  <= 32'd0;
         rbuf     <= 32'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         rdata    <= 32'd0;
         ram_addr <= 10'd0;
         ram_d    <= 8'd0;
         ram_we   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               err  <= 1'b0;
               if (req) begin
                  busy <= 1'b1;
                  if (size == 2'b11) begin
                     state <= DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     state    <= XFER;
                     k        <= 2'd0;
                     l_wr     <= wr;
                     l_uns    <= uns;
                     l_size   <= size;
                     l_wdata  <= wdata;
                     rbuf     <= 32'd0;
                     ram_addr <= addr;
                     ram_we   <= wr;
                     ram_d    <= wr ? wdata[7:0] : 8'd0;
                  end
               end
            end
            XFER: begin
               if (!l_wr) rbuf[{k, 3'b000} +: 8] <= ram_q;
               if (k == last_k) begin
                  state    <= DONE;
                  done     <= 1'b1;
                  k        <= 2'd0;
                  ram_addr <= 10'd0;
                  ram_we   <= 1'b0;
                  ram_d    <= 8'd0;
                  if (!l_wr) rdata <= load_val;
               end else begin
                  k        <= k_nxt;
                  ram_addr <= ram_addr + 10'd1;  // 10-bit add wraps 1023 -> 0
                  ram_d    <= l_wr ? l_wdata[{k_nxt, 3'b000} +: 8] : 8'd0;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               err   <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               err   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_byte_seq.sv
// Randomized bench for mem_byte_seq: a byte-array RAM model, plus a reference
// memory image and per-access expected outputs derived from the access rules.
module tb_mem_byte_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic        wr = 1'b0;
   logic [1:0]  size = 2'b00;
   logic        uns = 1'b0;
   logic [9:0]  addr = 10'd0;
   logic [31:0] wdata = 32'd0;
   logic        busy, done, err, ram_we;
   logic [31:0] rdata;
   logic [9:0]  ram_addr;
   logic [7:0]  ram_d, ram_q;

   logic [7:0]  mem [1024];
   logic [7:0]  ref_mem [1024];
   logic [31:0] exp_rdata = 32'd0;
   logic        pl_en = 1'b0;
   logic [9:0]  pl_a = 10'd0;
   logic [7:0]  pl_d = 8'd0;
   int          errors = 0;
   int          checks = 0;

   mem_byte_seq dut (
      .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .size(size), .uns(uns),
      .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
      .rdata(rdata), .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we),
      .ram_q(ram_q)
   );

   always #5 clk = ~clk;

   assign ram_q = mem[ram_addr];
   always @(posedge clk) begin
      if (pl_en) mem[pl_a] <= pl_d;
      else if (ram_we) mem[ram_addr] <= ram_d;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] s);
      return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
   endfunction

   // Called at a falling edge; returns at the falling edge of the first IDLE cycle.
   task automatic op(input logic w, input logic [1:0] s, input logic u,
                     input logic [9:0] a, input logic [31:0] d, input bit poke);
      int n;
      logic [31:0] v;
      logic [9:0]  ea;
      n = nbytes(s);
      req = 1'b1; wr = w; size = s; uns = u; addr = a; wdata = d;
      @(negedge clk);
      req = 1'b0;
      if (poke) begin
         req = 1'b1; addr = a + 10'd100; wr = ~w; wdata = ~d; size = 2'b10;
      end
      if (s == 2'b11) begin
         chk("ill_done", done, 1);
         chk("ill_err", err, 1);
         chk("ill_busy", busy, 1);
         chk("ill_we", ram_we, 0);
         chk("ill_rdata", rdata, exp_rdata);
      end else begin
         for (int i = 0; i < n; i++) begin
            if (i > 0) begin
               @(negedge clk);
               req = 1'b0;
            end
            ea = a + 10'(i);
            chk("xfer_busy", busy, 1);
            chk("xfer_done", done, 0);
            chk("xfer_addr", 32'(ram_addr), 32'(ea));
            chk("xfer_we", ram_we, w);
            if (w) chk("xfer_d", ram_d, d[8*i +: 8]);
         end
         @(negedge clk);
         req = 1'b0;
         v = 32'd0;
         for (int i = 0; i < n; i++) begin
            ea = a + 10'(i);
            if (w) ref_mem[ea] = d[8*i +: 8];
            else v |= 32'(ref_mem[ea]) << (8*i);
         end
         if (!w) begin
            if (n < 4 && !u && v[8*n-1]) v |= 32'hFFFF_FFFF << (8*n);
            exp_rdata = v;
         end
         chk("done_pulse", done, 1);
         chk("done_err", err, 0);
         chk("done_busy", busy, 1);
         chk("done_we", ram_we, 0);
         chk("done_addr", 32'(ram_addr), 0);
         chk("done_d", ram_d, 0);
         chk("done_rdata", rdata, exp_rdata);
      end
      @(negedge clk);
      req = 1'b0;
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_err", err, 0);
      chk("idle_we", ram_we, 0);
   endtask

   initial begin
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_we", ram_we, 0);
      chk("rst_addr", 32'(ram_addr), 0);
      chk("rst_d", ram_d, 0);

      // Preload RAM with random contents while held in reset.
      pl_en = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         @(negedge clk);
         pl_a = 10'(i);
         pl_d = 8'($urandom);
         ref_mem[i] = pl_d;
      end
      @(negedge clk);
      pl_en = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      op(1, 2'b10, 0, 10'h004, 32'hA1B2C3D4, 0);
      op(0, 2'b00, 0, 10'h007, 32'h0, 0);
      chk("byte_sext", rdata, 32'hFFFF_FFA1);
      op(0, 2'b01, 1, 10'h004, 32'h0, 0);
      chk("half_zext", rdata, 32'h0000_C3D4);
      op(0, 2'b01, 0, 10'h004, 32'h0, 0);
      chk("half_sext", rdata, 32'hFFFF_C3D4);
      op(1, 2'b10, 0, 10'h3FE, 32'h1357_9BDF, 0);
      op(0, 2'b10, 0, 10'h3FE, 32'h0, 0);
      chk("wrap_word", rdata, 32'h1357_9BDF);
      chk("wrap_ram0", mem[0], 8'h57);
      op(1, 2'b11, 0, 10'h010, 32'hDEAD_BEEF, 0);
      op(1, 2'b00, 0, 10'h020, 32'h0000_005A, 1);
      op(0, 2'b10, 1, 10'h020, 32'h0, 1);
      chk("ignore_ram", mem[10'h020 + 10'd100], ref_mem[10'h020 + 10'd100]);

      // Abort a word store after its second byte.
      req = 1'b1; wr = 1'b1; size = 2'b10; uns = 1'b0; addr = 10'h040; wdata = 32'h4433_2211;
      @(negedge clk); req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_we", ram_we, 0);
      chk("abort_addr", 32'(ram_addr), 0);
      chk("abort_d", ram_d, 0);
      chk("abort_rdata", rdata, 0);
      ref_mem[10'h040] = 8'h11;
      ref_mem[10'h041] = 8'h22;
      exp_rdata = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("abort_nodone", done, 0);
         chk("abort_nowe", ram_we, 0);
         @(negedge clk);
      end
      chk("abort_b0", mem[10'h040], 8'h11);
      chk("abort_b1", mem[10'h041], 8'h22);
      chk("abort_b2", mem[10'h042], ref_mem[10'h042]);
      chk("abort_b3", mem[10'h043], ref_mem[10'h043]);

      for (int t = 0; t < 80; t++) begin
         logic [9:0] ra;
         logic [1:0] rs;
         ra = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1018, 1023))
                                          : 10'($urandom_range(0, 15));
         rs = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         op(1'($urandom), rs, 1'($urandom), ra, $urandom, ($urandom_range(0, 7) == 0));
      end

      begin
         int mism;
         mism = 0;
         for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mism++;
         chk("ram_image", mism, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_byte_seq.md
MEM_BYTE_SEQ -- requirements
Module: mem_byte_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL update on the rising edge of clk.
REQ-002 clk  in  1  system clock; rising-edge active.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 req  in  1  access request; sampled only in IDLE.
REQ-005 wr  in  1  1 = store, 0 = load; sampled with req.
REQ-006 size  in  2  00 byte, 01 half, 10 word, 11 illegal; sampled with req.
REQ-007 uns  in  1  1 = zero-extend load, 0 = sign-extend; sampled with req.
REQ-008 addr  in  10  byte start address; sampled with req.
REQ-009 wdata  in  32  store data, little-endian, byte 0 = wdata[7:0]; sampled with req.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 err  out  1  one-cycle pulse, coincident with done, for size=11.
REQ-013 rdata  out  32  extended load result; held until the next load completes.
REQ-014 ram_addr  out  10  byte address to the downstream 8-bit RAM (1024 x 8).
REQ-015 ram_d  out  8  write byte to the RAM.
REQ-016 ram_we  out  1  RAM write enable; the RAM writes on the same clk edge.
REQ-017 ram_q  in  8  RAM combinational read data for ram_addr.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, XFER, DONE.
REQ-019 IDLE with req=1 and size!=11: SHALL latch wr/size/uns/addr/wdata, clear the byte counter k, and go to XFER.
REQ-020 IDLE with req=1 and size=11: SHALL go to DONE with err pending, making no RAM access.
REQ-021 req SHALL be ignored outside IDLE; no queueing.
REQ-022 Byte count n SHALL be 1, 2, or 4 for size 00, 01, 10.
REQ-023 In XFER, ram_addr SHALL equal (latched addr + k) mod 1024; the address wraps 1023->0; no alignment check.
REQ-024 Store in XFER: ram_we=1 and ram_d=wdata byte k.
REQ-025 Load in XFER: ram_we=0, and the clk edge SHALL capture ram_q into buffer byte k.
REQ-026 k SHALL increment once per XFER cycle; on the edge where k=n-1 the FSM SHALL go to DONE.
REQ-027 Load entering DONE: rdata SHALL be loaded with the n captured bytes, extended to 32 bits by uns (sign from bit 8n-1).
REQ-028 Store entering DONE: rdata SHALL be unchanged.
REQ-029 In DONE, done SHALL be 1 for exactly one cycle, and err SHALL be 1 only for the illegal-size case; the next edge SHALL go to IDLE.
REQ-030 Latency from the req-sampling edge to the done-high cycle SHALL be n+1 cycles (1 cycle for illegal size).
REQ-031 Back-to-back: the earliest next req SHALL be sampled on the edge leaving DONE +1, i.e. the first IDLE cycle.
REQ-032 Outside XFER, ram_we=0, ram_addr=0, and ram_d=0.

Reset
REQ-033 rst_n low at any time SHALL immediately force IDLE, set k=0, and set busy, done, err, rdata, ram_addr, ram_d, and ram_we to 0.
REQ-034 Reset during XFER SHALL abort the access; bytes already written stay in RAM, and no done pulse SHALL follow.

Verification
REQ-035 Word store: addr=0x004, wdata=0xA1B2C3D4 -> RAM[4..7]=D4,C3,B2,A1 over 4 ram_we cycles; done in cycle 5; busy high cycles 1-5.
REQ-036 Loads of those bytes: byte at 0x007 with uns=0 -> rdata=0xFFFFFFA1; half at 0x004 with uns=1 -> 0x0000C3D4; half with uns=0 -> 0xFFFFC3D4.
REQ-037 Wrap: word store at addr=0x3FE -> writes to 0x3FE, 0x3FF, 0x000, 0x001; a word load back returns the same value.
REQ-038 Illegal size: size=11 with req -> done=err=1 on the next cycle; ram_we never high; rdata unchanged.
REQ-039 Busy ignore: req pulsed during XFER with a different addr -> the in-flight access completes unchanged, and no second access occurs.
REQ-040 Mid-op reset: rst_n low after the 2nd byte of a word store -> outputs 0 immediately, only 2 bytes are written, and no done pulse occurs.
